// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop rx synchroniser, mid-bit sampling, 8N1 frame recovery.
// Define UART_RX_PARITY_EN to expect 8E1 frames and check even parity.
module uart_receiver #(
  parameter int UART_BITS_TRANSFERED = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic [UART_BITS_TRANSFERED-1:0] data,
  output logic valid,
  output logic framing_error,
  output logic parity_error,
  output logic busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (UART_BITS_TRANSFERED > 1) ? $clog2(UART_BITS_TRANSFERED) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_BITS_TRANSFERED - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP  = 3'd4,
    S_BREAK = 3'd5
  } state_t;

  state_t state, state_next;
  logic rx_meta, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [UART_BITS_TRANSFERED-1:0] shift;
  logic tick;
  logic valid_next, ferr_next;

  assign tick = (cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bit, parity_ok, perr_next;
  assign parity_ok = ~(^shift ^ par_bit);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= S_IDLE;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state   <= state_next;
    end
  end

  // The STOP decision is taken at mid stop bit so a start edge right after it is not missed.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!rx_s) state_next = S_START;
      S_START: if (cnt == CNT_HALF) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (tick && bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick) state_next = S_STOP;
`endif
      S_STOP:  if (tick) state_next = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    valid_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_next  = 1'b0;
`endif
    busy = (state != S_IDLE);
    if (state == S_STOP && tick) begin
      if (!rx_s) begin
        ferr_next = 1'b1;
      end else begin
`ifdef UART_RX_PARITY_EN
        valid_next = parity_ok;
        perr_next  = ~parity_ok;
`else
        valid_next = 1'b1;
`endif
      end
    end
  end

  // Counter restarts on every state change so each state measures from its own entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (state_next != state || state == S_IDLE || tick)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (state == S_IDLE) begin
        bit_idx <= '0;
      end else if (state == S_DATA && tick) begin
        shift[bit_idx] <= rx_s;
        bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + IDX_W'(1);
      end

      if (valid_next) data <= shift;
      valid         <= valid_next;
      framing_error <= ferr_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      if (state == S_PARITY && tick) par_bit <= rx_s;
      parity_error <= perr_next;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule
